// File: rtl/matrix_ctrl_pkg.sv
// Shared types and default widths for the matrix
// lookup arbitration slice.
package matrix_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int MTX_NUM_REQ   = 4;
  localparam int MTX_X_IDX     = 2;
  localparam int MTX_Y_IDX     = 2;
  localparam int MTX_NUM_WIDTH = 5;

endpackage

// File: rtl/matrix_arbiter_rr.sv
// Round-robin picker: first set request at or
// above the pointer, wrapping around.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  // search upward from the pointer, modulo N
  always_comb begin
    int   j;
    logic found;
    j     = 0;
    found = 1'b0;
    idx_o = '0;
    gnt_o = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found = 1'b1;
        idx_o = IW'(j);
      end
    end
    vld_o = found & en_i;
    if (vld_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/matrix_arbiter.sv
// Shares one matrix lookup among NUM_REQ
// requesters with a single outstanding lookup.
module matrix_arbiter
  import matrix_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = MTX_NUM_REQ,
  parameter int ID_W      = $clog2(NUM_REQ),
  parameter int X_IDX     = MTX_X_IDX,
  parameter int Y_IDX     = MTX_Y_IDX,
  parameter int NUM_WIDTH = MTX_NUM_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*X_IDX-1:0] req_x_i,
  input  logic [NUM_REQ*Y_IDX-1:0] req_y_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [X_IDX-1:0]         mtx_x_idx_o,
  output logic [Y_IDX-1:0]         mtx_y_idx_o,
  input  logic [NUM_WIDTH-1:0]     mtx_value_i,
  input  logic [X_IDX-1:0]         mtx_x_idx_i,
  input  logic [Y_IDX-1:0]         mtx_y_idx_i,
  input  logic                     mtx_valid_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic [NUM_WIDTH-1:0]     rsp_value_o,
  output logic [X_IDX-1:0]         rsp_x_o,
  output logic [Y_IDX-1:0]         rsp_y_o,
  output logic                     err_o
);

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        ptr_q, id_q;
  logic [ID_W-1:0]        gnt_idx, ptr_d;
  logic                   gnt_vld, grant_en;
  logic [X_IDX-1:0]       issx_q, sel_x;
  logic [Y_IDX-1:0]       issy_q, sel_y;
  logic [ID_W-1:0]        rid_q;
  logic [NUM_WIDTH-1:0]   rval_q;
  logic [X_IDX-1:0]       rx_q;
  logic [Y_IDX-1:0]       ry_q;
  logic                   err_q, bad;

  assign grant_en = (state_q == IDLE) ||
                    (state_q == HOLD && rsp_ready_i);

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_rr (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .en_i  (grant_en),
    .gnt_o (req_ready_o),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  assign sel_x = req_x_i[gnt_idx*X_IDX +: X_IDX];
  assign sel_y = req_y_i[gnt_idx*Y_IDX +: Y_IDX];
  assign ptr_d = (gnt_idx == ID_W'(NUM_REQ-1)) ?
                 '0 : gnt_idx + 1'b1;

  assign mtx_x_idx_o = gnt_vld ? sel_x : issx_q;
  assign mtx_y_idx_o = gnt_vld ? sel_y : issy_q;

  assign bad = !mtx_valid_i ||
               (mtx_x_idx_i != issx_q) ||
               (mtx_y_idx_i != issy_q);

  assign rsp_valid_o = (state_q == HOLD);
  assign rsp_id_o    = rid_q;
  assign rsp_value_o = rval_q;
  assign rsp_x_o     = rx_q;
  assign rsp_y_o     = ry_q;
  assign err_o       = err_q;

  // next-state logic for the lookup FSM
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_vld) state_d = WAIT;
      WAIT:    state_d = HOLD;
      HOLD:    if (rsp_ready_i)
                 state_d = gnt_vld ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state, pointer, issue and response registers
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      issx_q  <= '0;
      issy_q  <= '0;
      rid_q   <= '0;
      rval_q  <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gnt_vld) begin
        ptr_q  <= ptr_d;
        id_q   <= gnt_idx;
        issx_q <= sel_x;
        issy_q <= sel_y;
      end
      if (state_q == WAIT) begin
        rid_q  <= id_q;
        rval_q <= mtx_value_i;
        rx_q   <= mtx_x_idx_i;
        ry_q   <= mtx_y_idx_i;
        if (bad) err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_arbiter.sv
// Scoreboard bench for matrix_arbiter with a
// 1-cycle registered matrix model.
module tb_matrix_arbiter;

  typedef struct packed {
    logic [1:0] id;
    logic [4:0] val;
    logic [1:0] x;
    logic [1:0] y;
  } exp_t;

  logic       clk = 1'b0;
  logic       arstn = 1'b0;
  logic [3:0] req_valid = '0;
  logic [7:0] req_x = '0;
  logic [7:0] req_y = '0;
  logic [3:0] req_ready;
  logic [1:0] mx_o, my_o;
  logic [4:0] m_val;
  logic [1:0] m_x, m_y;
  logic       m_v;
  logic       mtx_valid;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [1:0] rsp_id;
  logic [4:0] rsp_value;
  logic [1:0] rsp_x, rsp_y;
  logic       err;
  logic       corrupt_x = 1'b0;
  logic       force_inv = 1'b0;
  logic       sb_en = 1'b1;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  matrix_arbiter dut (
    .clk_i       (clk),
    .arstn_i     (arstn),
    .req_valid_i (req_valid),
    .req_x_i     (req_x),
    .req_y_i     (req_y),
    .req_ready_o (req_ready),
    .mtx_x_idx_o (mx_o),
    .mtx_y_idx_o (my_o),
    .mtx_value_i (m_val),
    .mtx_x_idx_i (m_x),
    .mtx_y_idx_i (m_y),
    .mtx_valid_i (mtx_valid),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_value_o (rsp_value),
    .rsp_x_o     (rsp_x),
    .rsp_y_o     (rsp_y),
    .err_o       (err)
  );

  function automatic logic [4:0] mval(
    input logic [1:0] x, input logic [1:0] y);
    return 5'(4 * int'(y) + int'(x) + 1);
  endfunction

  // matrix model: registered value, echoes indices
  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      m_v <= 1'b0; m_val <= '0;
      m_x <= '0;   m_y <= '0;
    end else begin
      m_v   <= |req_ready;
      m_val <= mval(mx_o, my_o);
      m_x   <= mx_o ^ {1'b0, corrupt_x};
      m_y   <= my_o;
    end
  end
  assign mtx_valid = m_v & ~force_inv;

  // scoreboard: push on handshake, pop on response
  always @(negedge clk) begin
    if (!arstn) sb_q.delete();
    else if (sb_en) begin
      if (rsp_valid && rsp_ready) begin
        n_chk++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected id=%0d val=%0d",
                   rsp_id, rsp_value);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if ({rsp_id, rsp_value, rsp_x, rsp_y}
              !== e) begin
            n_fail++;
            $display("FAIL sb_rsp got %h exp %h",
              {rsp_id, rsp_value, rsp_x, rsp_y}, e);
          end
        end
      end
      for (int i = 0; i < 4; i++)
        if (req_valid[i] && req_ready[i])
          sb_q.push_back({2'(i),
            mval(req_x[i*2+:2], req_y[i*2+:2]),
            req_x[i*2+:2], req_y[i*2+:2]});
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    arstn = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    corrupt_x = 1'b0; force_inv = 1'b0;
    repeat (2) @(posedge clk);
    #1 arstn = 1'b1;
  endtask

  task automatic set_req(input int i,
    input logic [1:0] x, input logic [1:0] y);
    req_x[i*2+:2] = x;
    req_y[i*2+:2] = y;
  endtask

  task automatic test_reset();
    arstn = 1'b0; #1;
    n_chk++;
    if ({req_ready, rsp_valid, rsp_id, rsp_value,
         rsp_x, rsp_y, err, mx_o, my_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs got %h exp 0",
        {req_ready, rsp_valid, rsp_id, rsp_value,
         rsp_x, rsp_y, err, mx_o, my_o});
    end
  endtask

  task automatic test_single();
    do_reset();
    set_req(2, 2'd1, 2'd2);
    req_valid = 4'b0100;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_gnt got %b exp 0100",
               req_ready);
    end
    if (mx_o !== 2'd1 || my_o !== 2'd2) begin
      n_fail++;
      $display("FAIL single_issue got %0d,%0d exp 1,2",
               mx_o, my_o);
    end
    n_chk++;
    cyc(); req_valid = '0;
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early got %b exp 0",
               rsp_valid);
    end
    cyc();
    @(negedge clk);
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_value, rsp_x, rsp_y,
         err} !== {1'b1, 2'd2, 5'd10, 2'd1, 2'd2,
         1'b0}) begin
      n_fail++;
      $display("FAIL single_rsp got v%b id%0d val%0d x%0d y%0d e%b exp v1 id2 val10 x1 y2 e0",
        rsp_valid, rsp_id, rsp_value, rsp_x, rsp_y, err);
    end
    cyc();
  endtask

  task automatic test_round_robin();
    int gid[$];
    int gcy[$];
    do_reset();
    for (int i = 0; i < 4; i++)
      set_req(i, 2'(i), 2'(3 - i));
    req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (req_ready[i]) begin
          gid.push_back(i);
          gcy.push_back(c);
        end
      cyc();
    end
    req_valid = '0;
    n_chk++;
    if (gid.size() != 5) begin
      n_fail++;
      $display("FAIL rr_count got %0d exp 5",
               gid.size());
    end
    for (int k = 0; k < gid.size() && k < 5; k++) begin
      n_chk++;
      if (gid[k] != k % 4 || gcy[k] != 2 * k) begin
        n_fail++;
        $display("FAIL rr_order[%0d] got id%0d@%0d exp id%0d@%0d",
          k, gid[k], gcy[k], k % 4, 2 * k);
      end
    end
    repeat (4) cyc();
  endtask

  task automatic test_backpressure();
    int t;
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      set_req(i, 2'(i), 2'(3 - i));
    req_valid = 4'hF;
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 10) begin
      cyc(); @(negedge clk); t++;
    end
    n_chk++;
    if (!rsp_valid) begin
      n_fail++;
      $display("FAIL bp_timeout got 0 exp rsp_valid");
    end
    for (int c = 0; c < 5; c++) begin
      n_chk++;
      if ({req_ready, rsp_valid, rsp_id, rsp_value,
           rsp_x, rsp_y} !== {4'b0, 1'b1, 2'd0,
           5'd13, 2'd0, 2'd3}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got r%b v%b id%0d val%0d exp r0000 v1 id0 val13",
          c, req_ready, rsp_valid, rsp_id, rsp_value);
      end
      cyc(); @(negedge clk);
    end
    cyc(); rsp_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_release got %b exp 0010",
               req_ready);
    end
    cyc(); req_valid = '0;
    repeat (4) cyc();
  endtask

  task automatic test_wrap();
    do_reset();
    set_req(3, 2'd3, 2'd3);
    set_req(0, 2'd0, 2'd1);
    set_req(2, 2'd2, 2'd0);
    req_valid = 4'b1000;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrap_g3 got %b exp 1000",
               req_ready);
    end
    cyc(); req_valid = 4'b0101;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL wrap_wait got %b exp 0000",
               req_ready);
    end
    cyc();
    @(negedge clk);
    n_chk++;
    if ({req_ready, rsp_id, rsp_value} !==
        {4'b0001, 2'd3, 5'd16}) begin
      n_fail++;
      $display("FAIL wrap_g0 got r%b id%0d val%0d exp r0001 id3 val16",
        req_ready, rsp_id, rsp_value);
    end
    cyc(); req_valid = '0;
    repeat (4) cyc();
  endtask

  task automatic err_run(input string nm);
    set_req(1, 2'd1, 2'd1);
    req_valid = 4'b0010;
    cyc(); req_valid = '0;
    @(negedge clk);
    n_chk++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_early got %b exp 0", nm, err);
    end
    for (int c = 0; c < 4; c++) begin
      cyc();
      @(negedge clk);
      n_chk++;
      if (err !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_sticky[%0d] got %b exp 1",
                 nm, c, err);
      end
    end
  endtask

  task automatic test_err();
    sb_en = 1'b0;
    do_reset();
    corrupt_x = 1'b1;
    err_run("err_x");
    do_reset();
    n_chk++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear got %b exp 0", err);
    end
    force_inv = 1'b1;
    err_run("err_inv");
    do_reset();
    sb_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int t;
    do_reset();
    set_req(0, 2'd2, 2'd1);
    req_valid = 4'b0001;
    cyc(); req_valid = '0;
    arstn = 1'b0; #1;
    n_chk++;
    if ({req_ready, rsp_valid, rsp_id, rsp_value,
         rsp_x, rsp_y, err, mx_o, my_o} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outs got %h exp 0",
        {req_ready, rsp_valid, rsp_id, rsp_value,
         rsp_x, rsp_y, err, mx_o, my_o});
    end
    cyc(); arstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_stale[%0d] got 1 exp 0",
                 c);
      end
      cyc();
    end
    set_req(1, 2'd3, 2'd0);
    req_valid = 4'b0010;
    cyc(); req_valid = '0;
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 6) begin
      cyc(); @(negedge clk); t++;
    end
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_value} !==
        {1'b1, 2'd1, 5'd4}) begin
      n_fail++;
      $display("FAIL rstmid_new got v%b id%0d val%0d exp v1 id1 val4",
        rsp_valid, rsp_id, rsp_value);
    end
    repeat (3) cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_err();
    test_reset_mid();
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got %0d exp 0",
               sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
